// File: rtl/xyt_frame_serializer.sv
// FIFO-buffered UART-style serializer for 6-bit {t,y,x} samples; XYT_SERIALIZER_PARITY_EN adds an even parity bit.
// Latency: push at edge N into an idle, empty block starts the frame at N+1; sample_ready is registered !full, overflowing samples set a sticky flag.

module xyt_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push_vld,
  input  logic [W-1:0]            i_push_dat,
  output logic                    o_push_rdy,
  input  logic                    i_pop,
  output logic [W-1:0]            o_pop_dat,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_rdy;
  logic          w_push;
  logic          w_pop;
  logic [PW:0]   w_count_nxt;

  // Push is gated by the registered ready, so a full FIFO refuses even when a pop coincides.
  assign w_push      = i_push_vld & r_rdy;
  assign w_pop       = i_pop & (r_count != '0);
  assign w_count_nxt = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy    <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_rdy   <= (w_count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_push_rdy = r_rdy;
  assign o_pop_dat  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
endmodule

module xyt_frame_serializer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [5:0]                   sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         tx_out,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef XYT_SERIALIZER_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [5:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_overflow;
  logic          w_pop;
  logic          w_rdy;
  logic          w_tick;
  logic          w_has_data;
  logic [5:0]    w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;
`ifdef XYT_SERIALIZER_PARITY_EN
  logic          r_par, w_par_nxt;
`endif

  xyt_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (6)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (sample_valid),
    .i_push_dat (sample_in),
    .o_push_rdy (w_rdy),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_count    (w_count)
  );

  assign w_tick     = (r_baud == BAUD_LAST);
  assign w_has_data = (w_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
`ifdef XYT_SERIALIZER_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (r_state != IDLE) w_baud_nxt = w_tick ? '0 : r_baud + BW'(1);

    case (r_state)
      IDLE: begin
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_baud_nxt  = '0;
          w_state_nxt = START;
`ifdef XYT_SERIALIZER_PARITY_EN
          w_par_nxt   = ^w_head;
`endif
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit == 3'd5) begin
`ifdef XYT_SERIALIZER_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[5:1]};
          end
        end
      end
`ifdef XYT_SERIALIZER_PARITY_EN
      PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        if (w_tick) begin
          // Chain straight into the next start bit when more samples are waiting.
          if (w_has_data) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
`ifdef XYT_SERIALIZER_PARITY_EN
            w_par_nxt   = ^w_head;
`endif
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level is decoded from the next state so tx_out comes straight from a flop.
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef XYT_SERIALIZER_PARITY_EN
      PARITY:  w_tx_nxt = w_par_nxt;
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
`ifdef XYT_SERIALIZER_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_overflow <= r_overflow | (sample_valid & ~w_rdy);
`ifdef XYT_SERIALIZER_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  assign sample_ready = w_rdy;
  assign tx_out       = r_tx;
  assign busy         = (r_state != IDLE);
  assign fifo_count   = w_count;
  assign overflow     = r_overflow;
endmodule

// File: tb/tb_xyt_frame_serializer.sv
// Randomized bench for xyt_frame_serializer against a queue-based line model.
// The model holds pending samples and the remaining per-cycle line levels of the current frame.
module tb_xyt_frame_serializer;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef XYT_SERIALIZER_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  localparam int FRAME_LEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       tx_out;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt;

  logic [5:0] m_q[$];
  logic       m_line[$];
  logic       m_ovf;

  xyt_frame_serializer #(
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .tx_out       (tx_out),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_line.delete();
    m_ovf = 1'b0;
  endtask

  task automatic load_frame(input logic [5:0] d);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 6; i++) bits.push_back(d[i]);
`ifdef XYT_SERIALIZER_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[b]) for (int c = 0; c < CPB; c++) m_line.push_back(bits[b]);
  endtask

  // One clock edge of the reference: the ending cycle leaves the line, an idle or just-finished
  // line takes the queue head as it stood before the edge, then an accepted sample joins the queue.
  task automatic model_edge(input logic v, input logic [5:0] d);
    logic acc;
    logic [5:0] hd;
    acc = v && (m_q.size() < DEPTH);
    if (v && !acc) m_ovf = 1'b1;
    if (m_line.size() > 0) void'(m_line.pop_front());
    if (m_line.size() == 0 && m_q.size() > 0) begin
      hd = m_q.pop_front();
      load_frame(hd);
    end
    if (acc) m_q.push_back(d);
  endtask

  task automatic check_outputs();
    logic exp_tx;
    exp_tx = (m_line.size() > 0) ? m_line[0] : 1'b1;
    check_eq("tx_out", 32'(tx_out), 32'(exp_tx));
    check_eq("busy", 32'(busy), 32'(m_line.size() > 0));
    check_eq("sample_ready", 32'(sample_ready), 32'(m_q.size() < DEPTH));
    check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Inputs change at the negedge; outputs are checked at the following negedge.
  task automatic cycle(input logic v, input logic [5:0] d);
    sample_valid = v;
    sample_in    = d;
    @(posedge clk);
    if (rst_n) model_edge(v, d);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    repeat (20) cycle(1'b0, 6'd0);

    busy_cnt = 0;
    cycle(1'b1, 6'h27);
    check_eq("tx_idle_at_push", 32'(tx_out), 32'd1);
    cycle(1'b0, 6'd0);
    check_eq("start_bit_low", 32'(tx_out), 32'd0);
    if (busy) busy_cnt++;
    for (int i = 0; i < FRAME_LEN + 8; i++) begin
      cycle(1'b0, 6'd0);
      if (busy) busy_cnt++;
    end
    check_eq("busy_len", 32'(busy_cnt), 32'(FRAME_LEN));

    cycle(1'b1, 6'h3F);
    cycle(1'b1, 6'h00);
    check_eq("b2b_count", 32'(fifo_count), 32'd1);
    repeat (2 * FRAME_LEN + 10) cycle(1'b0, 6'd0);

    for (int i = 0; i < 6; i++) cycle(1'b1, 6'($urandom));
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_full_rdy", 32'(sample_ready), 32'd0);
    repeat (6 * FRAME_LEN) cycle(1'b0, 6'd0);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    cycle(1'b1, 6'($urandom));
    cycle(1'b1, 6'($urandom));
    cycle(1'b1, 6'($urandom));
    repeat (4 * CPB) cycle(1'b0, 6'd0);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_tx", 32'(tx_out), 32'd1);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    model_reset();
    repeat (2) cycle(1'b0, 6'd0);
    rst_n = 1'b1;
    repeat (2 * FRAME_LEN) cycle(1'b0, 6'd0);

    for (int i = 0; i < 1600; i++) begin
      int pct;
      pct = ((i / 200) % 2 == 1) ? 85 : 15;
      cycle(($urandom_range(0, 99) < pct), 6'($urandom));
    end
    repeat ((DEPTH + 2) * FRAME_LEN) cycle(1'b0, 6'd0);
    check_eq("drained_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
